// File: rtl/sobel_window_buffer.sv
// sobel_window_buffer: turns a raster pixel stream into 3x3 neighbourhood windows,
// one per interior pixel, using two column-indexed line buffers and a column shift window.
module sobel_window_buffer #(
    parameter int PIX_W     = 24,
    parameter int MAX_WIDTH = 2500
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [15:0]        cfg_width,
    input  logic [15:0]        cfg_height,
    input  logic               pix_valid,
    input  logic [PIX_W-1:0]   pix_data,
    output logic               pix_ready,
    output logic               win_valid,
    output logic [9*PIX_W-1:0] win_data,
    input  logic               win_ready,
    output logic               busy,
    output logic               done
);
    localparam int AW = MAX_WIDTH > 1 ? $clog2(MAX_WIDTH) : 1;
    localparam logic [15:0] MAX_W = 16'(MAX_WIDTH);
    localparam int P = PIX_W;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_n;

    logic [15:0]    width, height, col, row;
    logic [P-1:0]   lb0 [MAX_WIDTH];
    logic [P-1:0]   lb1 [MAX_WIDTH];
    logic [3*P-1:0] c0, c1, new_col;
    logic [AW-1:0]  idx;
    logic           accept, bad_cfg, eol, last, emit, done_n;

    assign idx       = col[AW-1:0];
    assign new_col   = {lb1[idx], lb0[idx], pix_data};
    assign pix_ready = state == RUN && (!win_valid || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign bad_cfg   = cfg_width < 16'd3 || cfg_height < 16'd3 || cfg_width > MAX_W;
    assign eol       = col == width - 16'd1;
    assign last      = eol && row == height - 16'd1;
    assign emit      = accept && row >= 16'd2 && col >= 16'd2;
    assign busy      = state != IDLE;

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n = bad_cfg ? IDLE : RUN;
                done_n  = bad_cfg;
            end
            RUN: if (accept && last) state_n = FLUSH;
            FLUSH: if (win_valid && win_ready) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            width     <= '0;
            height    <= '0;
            col       <= '0;
            row       <= '0;
            c0        <= '0;
            c1        <= '0;
            win_valid <= 1'b0;
            win_data  <= '0;
        end else begin
            state <= state_n;
            done  <= done_n;
            if (state == IDLE && start) begin
                width  <= cfg_width;
                height <= cfg_height;
                col    <= '0;
                row    <= '0;
            end
            if (accept) begin
                col <= eol ? 16'd0 : col + 16'd1;
                row <= eol ? row + 16'd1 : row;
                c0  <= c1;
                c1  <= new_col;
            end
            // Window = two previous columns plus the incoming one, emitted row-major.
            if (emit)
                win_data <= {c0[3*P-1 -: P], c1[3*P-1 -: P], new_col[3*P-1 -: P],
                             c0[2*P-1 -: P], c1[2*P-1 -: P], new_col[2*P-1 -: P],
                             c0[P-1:0],      c1[P-1:0],      new_col[P-1:0]};
            win_valid <= emit || (win_valid && !win_ready);
        end
    end

    // Line buffers hold the two previous rows and are never cleared.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[idx] <= lb0[idx];
            lb0[idx] <= pix_data;
        end
    end
endmodule

// File: tb/tb_sobel_window_buffer.sv
// tb_sobel_window_buffer: randomized frames checked against a direct neighbourhood model.
module tb_sobel_window_buffer;
    localparam int P    = 24;
    localparam int MAXW = 16;

    logic           clk = 0, rst = 1, start = 0, pix_valid = 0, win_ready = 0;
    logic [15:0]    cfg_width = 0, cfg_height = 0;
    logic [P-1:0]   pix_data = '0;
    logic           pix_ready, win_valid, busy, done;
    logic [9*P-1:0] win_data;

    int             checks = 0, errors = 0, cyc = 0;
    logic [P-1:0]   pix [64];
    logic [9*P-1:0] exp_q[$], got_q[$];
    int             hs_cyc, done_cyc, done_cnt, stall_cnt, proto_bad, iters;
    bit             was_stall, timed_out, busy_before, busy_at_done;
    logic [9*P-1:0] held;

    sobel_window_buffer #(.PIX_W(P), .MAX_WIDTH(MAXW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .win_valid(win_valid), .win_data(win_data), .win_ready(win_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Records handshakes and done pulses; tallies stall-protocol violations.
    always @(negedge clk) begin
        if (rst) was_stall = 0;
        else begin
            if (win_valid && win_ready) begin
                got_q.push_back(win_data);
                hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (was_stall && (!win_valid || win_data !== held)) proto_bad++;
            if (win_valid && !win_ready) begin
                stall_cnt++;
                if (pix_ready) proto_bad++;
            end
            was_stall = win_valid && !win_ready;
            held      = win_data;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic run_frame(input int w, input int h, input int drop, input int stall,
                             input int hold, input bit inject, input int abort_at);
        int k = 0, held_n = 0;
        bit injected = 0;
        logic [9*P-1:0] v;
        got_q.delete();
        exp_q.delete();
        for (int r = 2; r < h; r++)
            for (int c = 2; c < w; c++) begin
                v = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        v = {v[8*P-1:0], pix[(r - 2 + i) * w + c - 2 + j]};
                exp_q.push_back(v);
            end
        done_cnt = 0; stall_cnt = 0; proto_bad = 0; iters = 0; timed_out = 0;
        cfg_width = 16'(w); cfg_height = 16'(h); start = 1;
        @(posedge clk); #1;
        start = 0;
        while (!done) begin
            start = 0;
            if (inject && !injected && k == w * h / 2) begin
                start = 1; cfg_width = 3; cfg_height = 3; injected = 1;
            end
            pix_valid = k < w * h && $urandom_range(99) >= drop;
            pix_data  = pix_valid ? pix[k] : P'($urandom());
            if (hold > 0 && got_q.size() >= 1 && held_n < hold) begin
                win_ready = 0;
                held_n++;
            end else win_ready = $urandom_range(99) >= stall;
            busy_before = busy;
            @(negedge clk);
            if (pix_valid && pix_ready) k++;
            @(posedge clk); #1;
            iters++;
            if (abort_at >= 0 && k == abort_at) break;
            if (iters > 5000) begin timed_out = 1; break; end
        end
        busy_at_done = busy;
        start = 0; pix_valid = 0; win_ready = 0;
        if (abort_at < 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1; pix_valid = 1; win_ready = 1;
        @(posedge clk); #1;
        checks++;
        if ({pix_ready, win_valid, busy, done} !== 4'b0) begin
            errors++;
            $display("FAIL reset flags: got %b exp 0000", {pix_ready, win_valid, busy, done});
        end
        checks++;
        if (win_data !== '0) begin errors++; $display("FAIL reset win_data: got %h exp 0", win_data); end
        rst = 0; pix_valid = 0; win_ready = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_4x4();
        logic [9*P-1:0] first = {24'd0, 24'd1, 24'd2, 24'd4, 24'd5, 24'd6, 24'd8, 24'd9, 24'd10};
        logic [9*P-1:0] lastw = {24'd5, 24'd6, 24'd7, 24'd9, 24'd10, 24'd11, 24'd13, 24'd14, 24'd15};
        for (int i = 0; i < 16; i++) pix[i] = P'(i);
        run_frame(4, 4, 0, 0, 0, 0, -1);
        checks++;
        if (timed_out) begin errors++; $display("FAIL 4x4 timeout: got timeout exp done"); end
        checks++;
        if (got_q.size() != 4) begin errors++; $display("FAIL 4x4 count: got %0d exp 4", got_q.size()); end
        else begin
            checks++;
            if (got_q[0] !== first) begin errors++; $display("FAIL 4x4 first: got %h exp %h", got_q[0], first); end
            checks++;
            if (got_q[3] !== lastw) begin errors++; $display("FAIL 4x4 last: got %h exp %h", got_q[3], lastw); end
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL 4x4 win%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
            end
        end
        checks++;
        if (done_cyc != hs_cyc + 1) begin errors++; $display("FAIL 4x4 done timing: got cycle %0d exp %0d", done_cyc, hs_cyc + 1); end
        checks++;
        if (iters != 17) begin errors++; $display("FAIL 4x4 throughput: got %0d cycles exp 17", iters); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL 4x4 done pulses: got %0d exp 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 16; i++) pix[i] = P'(i);
        run_frame(4, 4, 0, 0, 5, 0, -1);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp count: got %0d exp %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp win%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        checks++;
        if (stall_cnt != 5) begin errors++; $display("FAIL bp stall cycles: got %0d exp 5", stall_cnt); end
        checks++;
        if (proto_bad != 0) begin errors++; $display("FAIL bp protocol: got %0d violations exp 0", proto_bad); end
    endtask

    task automatic test_3x3();
        logic [9*P-1:0] all9 = {24'd0, 24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 24'd6, 24'd7, 24'd8};
        for (int i = 0; i < 9; i++) pix[i] = P'(i);
        run_frame(3, 3, 0, 0, 0, 0, -1);
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL 3x3 count: got %0d exp 1", got_q.size()); end
        else begin
            checks++;
            if (got_q[0] !== all9) begin errors++; $display("FAIL 3x3 window: got %h exp %h", got_q[0], all9); end
        end
        checks++;
        if ({busy_before, busy_at_done} !== 2'b10) begin
            errors++;
            $display("FAIL 3x3 busy at done: got %b exp 10", {busy_before, busy_at_done});
        end
    endtask

    task automatic test_bad_cfg();
        int bad;
        logic [15:0] ws [2] = '{16'd2, 16'd17};
        logic [15:0] hs [2] = '{16'd10, 16'd3};
        for (int t = 0; t < 2; t++) begin
            bad = 0;
            cfg_width = ws[t]; cfg_height = hs[t]; start = 1;
            @(posedge clk); #1;
            start = 0;
            checks++;
            if ({done, busy} !== 2'b10) begin errors++; $display("FAIL badcfg%0d done/busy: got %b exp 10", t, {done, busy}); end
            pix_valid = 1; win_ready = 1;
            repeat (6) begin
                @(posedge clk); #1;
                if (win_valid || pix_ready || done || busy) bad++;
            end
            pix_valid = 0;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL badcfg%0d idle: got %0d active cycles exp 0", t, bad); end
        end
        for (int i = 0; i < 48; i++) pix[i] = P'($urandom());
        run_frame(MAXW, 3, 10, 10, 0, 0, -1);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL maxw count: got %0d exp %0d", got_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL maxw win%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 30; i++) pix[i] = {8'hAA, 16'($urandom())};
        run_frame(6, 5, 0, 0, 0, 0, 18);
        rst = 1;
        #1;
        checks++;
        if ({pix_ready, win_valid, busy, done} !== 4'b0 || win_data !== '0) begin
            errors++;
            $display("FAIL midreset outputs: got %b/%h exp 0000/0", {pix_ready, win_valid, busy, done}, win_data);
        end
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) pix[i] = {8'h55, 16'($urandom())};
        run_frame(5, 4, 20, 20, 0, 0, -1);
        checks++;
        if (got_q.size() != 6) begin errors++; $display("FAIL postreset count: got %0d exp 6", got_q.size()); end
        else foreach (exp_q[i]) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL postreset win%0d: got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int dims [2][2] = '{'{8, 3}, '{3, 8}};
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 24; i++) pix[i] = P'($urandom());
            run_frame(dims[f][0], dims[f][1], 30, 25, 0, 1, -1);
            checks++;
            if (got_q.size() != 6) begin errors++; $display("FAIL b2b%0d count: got %0d exp 6", f, got_q.size()); end
            else foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b%0d win%0d: got %h exp %h", f, i, got_q[i], exp_q[i]); end
            end
            checks++;
            if (done_cnt != 1 || proto_bad != 0) begin
                errors++;
                $display("FAIL b2b%0d done/protocol: got %0d/%0d exp 1/0", f, done_cnt, proto_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_4x4();
        test_backpressure();
        test_3x3();
        test_bad_cfg();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
